data_sram_ctrl: RTL and testbench
=================================

// Module: data_sram_ctrl
// PURPOSE
// Responder for the CPU data-memory port (re/we/mask/addr/data). It serves each
// request against an external 32-bit asynchronous SRAM.
// Each access takes several cycles, so the block raises stallreq_o to the pipeline
// ctrl unit until the access completes.
// It sits between the cpu top-level RAM port and the board SRAM pins. Tristate
// buffering of the SRAM data bus lives outside this block.
// PARAMETERS
// ADDR_W      20  SRAM word-address width; word address = ram_addr_i[ADDR_W+1:2]
// READ_WAIT   2   cycles OE_n held low before read data is sampled (>=1)
// WRITE_WAIT  2   cycles WE_n held low per write (>=1)
// PORTS
// clk          in   1       clock
// rst          in   1       synchronous reset, active-high
// ram_addr_i   in   32      byte address from CPU mem stage
// ram_data_i   in   32      write data from CPU
// ram_re_i     in   1       read request
// ram_we_i     in   1       write request
// ram_mask_i   in   4       byte enables, active-high; bit i -> bits [8i+7:8i]
// ram_data_o   out  32      read data to CPU, registered, valid in DONE and after
// stallreq_o   out  1       stall request to ctrl
// sram_addr_o  out  ADDR_W  SRAM word address
// sram_data_o  out  32      SRAM write data
// sram_data_oe out  1       1 = drive SRAM data bus
// sram_data_i  in   32      SRAM read data
// sram_ce_n    out  1       chip enable, active-low
// sram_oe_n    out  1       output enable, active-low
// sram_we_n    out  1       write enable, active-low
// sram_be_n    out  4       byte enables, active-low (= ~mask on write; 4'h0 on read)
// BEHAVIOUR
// - Reset values: all SRAM strobes high, sram_be_n=4'hF, sram_data_oe=0,
//   sram_addr_o=0, sram_data_o=0, ram_data_o=0, stallreq_o=0, state IDLE, counter 0.
// - Reset mid-access: all strobes deassert on that same edge and no data is latched.
// - States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE. SRAM outputs are registered.
// - stallreq_o = (state==IDLE & (re|we)) | (state in RD/WR_*). It is combinational
//   so the pipeline stalls in the request cycle itself. It is 0 in DONE.
// - CPU holds addr/data/mask/re/we stable while stallreq_o=1.
// - IDLE with we=1 (priority over re) and mask!=0 -> WR_SETUP:
//   latch addr, data and ~mask; ce_n=0; data_oe=1.
// - IDLE with we=1 and mask==0 -> DONE directly. No SRAM strobe; 1 stall cycle.
// - IDLE with re=1 (we=0) -> RD: ce_n=0, oe_n=0, be_n=0, counter=READ_WAIT-1.
// - RD: decrement counter. At counter==0, latch sram_data_i into ram_data_o,
//   release oe_n/ce_n, go to DONE.
// - Read stall = 1+READ_WAIT cycles; ram_data_o is valid in the DONE cycle.
// - WR_SETUP (1 cycle): go to WR_PULSE with we_n=0 and counter=WRITE_WAIT-1.
// - WR_PULSE: decrement counter. At 0, we_n=1 and go to WR_HOLD.
// - WR_HOLD (1 cycle): address and data still driven. Then ce_n=1, data_oe=0,
//   go to DONE.
// - Write stall = 3+WRITE_WAIT cycles.
// - DONE -> IDLE unconditionally. The still-present old request is not re-accepted.
//   A request seen in the following IDLE cycle is treated as new.
// - ram_data_o changes only on read completion. Writes leave it unchanged.
// - Address/data/be outputs are stable from the first asserted strobe until after
//   the last deasserted strobe. we_n and oe_n are never low together.
// TESTING
// - Read, READ_WAIT=2, sram_data_i=32'hDEADBEEF, addr=32'h0000_0010:
//   stallreq_o=1 for 3 cycles, sram_addr_o=4, DONE cycle ram_data_o=32'hDEADBEEF.
// - Write, addr=32'h0000_0008, data=32'h1234_5678, mask=4'b0011:
//   sram_be_n=4'b1100, we_n low exactly 2 cycles, oe_n stays high, stall 5 cycles.
// - Back-to-back: write then read of the same address is accepted in the IDLE cycle
//   after DONE. No strobe overlap; read returns the model's written bytes.
// - re=1 and we=1 together with mask=4'hF: write performed, oe_n never asserted,
//   ram_data_o unchanged.
// - Write with mask=0: stallreq_o=1 for one cycle, no SRAM strobes, DONE then IDLE.
// - rst asserted during WR_PULSE: next cycle we_n=1, ce_n=1, data_oe=0,
//   stallreq_o=0, state IDLE; no ram_data_o update.

Source files
------------

// File: rtl/data_sram_ctrl.sv
// Responder for the CPU data-memory port against an external 32-bit asynchronous SRAM.
// Each access runs a multi-cycle strobe sequence while the pipeline is held via stallreq_o.
module data_sram_ctrl #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned READ_WAIT  = 2,
  parameter int unsigned WRITE_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ram_addr_i,
  input  logic [31:0]       ram_data_i,
  input  logic              ram_re_i,
  input  logic              ram_we_i,
  input  logic [3:0]        ram_mask_i,
  output logic [31:0]       ram_data_o,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_data_o,
  output logic              sram_data_oe,
  input  logic [31:0]       sram_data_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  localparam int unsigned MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int unsigned CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;

  // Byte-lane and out-of-range address bits are not used by a word-addressed SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ram_addr_i[31:ADDR_W+2], ram_addr_i[1:0]};

  // Combinational so the pipeline stalls in the request cycle itself.
  assign stallreq_o = ((state == IDLE) && (ram_re_i || ram_we_i)) ||
                      (state == RD) || (state == WR_SETUP) ||
                      (state == WR_PULSE) || (state == WR_HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ram_data_o   <= '0;
      sram_addr_o  <= '0;
      sram_data_o  <= '0;
      sram_data_oe <= 1'b0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_be_n    <= 4'hF;
    end else begin
      case (state)
        IDLE: begin
          // Write wins over read; an all-zero mask write touches no SRAM pins.
          if (ram_we_i) begin
            if (ram_mask_i != 4'h0) begin
              sram_addr_o  <= ram_addr_i[ADDR_W+1:2];
              sram_data_o  <= ram_data_i;
              sram_be_n    <= ~ram_mask_i;
              sram_ce_n    <= 1'b0;
              sram_data_oe <= 1'b1;
              state        <= WR_SETUP;
            end else begin
              state <= DONE;
            end
          end else if (ram_re_i) begin
            sram_addr_o <= ram_addr_i[ADDR_W+1:2];
            sram_be_n   <= 4'h0;
            sram_ce_n   <= 1'b0;
            sram_oe_n   <= 1'b0;
            cnt         <= CNT_W'(READ_WAIT - 1);
            state       <= RD;
          end
        end
        RD: begin
          if (cnt == '0) begin
            ram_data_o <= sram_data_i;
            sram_oe_n  <= 1'b1;
            sram_ce_n  <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WR_SETUP: begin
          sram_we_n <= 1'b0;
          cnt       <= CNT_W'(WRITE_WAIT - 1);
          state     <= WR_PULSE;
        end
        WR_PULSE: begin
          if (cnt == '0) begin
            sram_we_n <= 1'b1;
            state     <= WR_HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WR_HOLD: begin
          // Address and data stay driven one cycle past the rising we_n.
          sram_ce_n    <= 1'b1;
          sram_data_oe <= 1'b0;
          state        <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Bench for data_sram_ctrl: behavioural SRAM plus a word-array reference model,
// directed scenarios followed by randomized transactions.
module tb_data_sram_ctrl;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned RW     = 2;
  localparam int unsigned WW     = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       ram_addr_i, ram_data_i, ram_data_o, sram_data_o, sram_data_i;
  logic              ram_re_i, ram_we_i, stallreq_o, sram_data_oe;
  logic [3:0]        ram_mask_i, sram_be_n;
  logic [ADDR_W-1:0] sram_addr_o;
  logic              sram_ce_n, sram_oe_n, sram_we_n;

  int total = 0;
  int bad   = 0;

  data_sram_ctrl #(.ADDR_W(ADDR_W), .READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .clk(clk), .rst(rst),
    .ram_addr_i(ram_addr_i), .ram_data_i(ram_data_i),
    .ram_re_i(ram_re_i), .ram_we_i(ram_we_i), .ram_mask_i(ram_mask_i),
    .ram_data_o(ram_data_o), .stallreq_o(stallreq_o),
    .sram_addr_o(sram_addr_o), .sram_data_o(sram_data_o), .sram_data_oe(sram_data_oe),
    .sram_data_i(sram_data_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : (32'h5A00_0000 ^ (32'(i) * 32'h0101_0111));
  endfunction

  // Behavioural SRAM: 16 words, reloaded on reset, byte writes while we_n is low.
  logic [31:0] sram_mem [16];
  assign sram_data_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr_o[3:0]] : 32'hBAD0_BAD0;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) sram_mem[i] <= init_word(i);
    end else if (!sram_ce_n && !sram_we_n && sram_data_oe) begin
      for (int i = 0; i < 4; i++)
        if (!sram_be_n[i]) sram_mem[sram_addr_o[3:0]][8*i +: 8] <= sram_data_o[8*i +: 8];
    end
  end

  // Pin monitor: strobe cycle counts and stability of address/data/byte enables.
  logic [19:0] exp_addr;
  logic [3:0]  exp_be;
  logic [31:0] exp_wdata;
  int we_low = 0, oe_low = 0, ce_low = 0, doe_high = 0, overlap = 0, pin_err = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (!sram_we_n) we_low++;
      if (!sram_oe_n) oe_low++;
      if (!sram_ce_n) ce_low++;
      if (sram_data_oe) doe_high++;
      if ((!sram_we_n && !sram_oe_n) || ((!sram_we_n || !sram_oe_n) && sram_ce_n)) overlap++;
      if (!sram_ce_n && ((sram_addr_o !== exp_addr) || (sram_be_n !== exp_be))) pin_err++;
      if (sram_data_oe && (sram_data_o !== exp_wdata)) pin_err++;
    end
  end

  logic [31:0] model_mem [16];
  logic [31:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_mem[i] = init_word(i);
    last_rd = 32'h0;
  endtask

  // One CPU request, issued at posedge+1 and held until stallreq_o drops.
  task automatic txn(input logic re, input logic we, input logic [3:0] mask,
                     input logic [31:0] addr, input logic [31:0] data);
    int w, stalls, e_st, e_we, e_oe, e_ce, e_doe;
    int s_we, s_oe, s_ce, s_doe, s_ov, s_pe;
    w = int'(addr[5:2]);
    s_we = we_low; s_oe = oe_low; s_ce = ce_low; s_doe = doe_high; s_ov = overlap; s_pe = pin_err;
    exp_addr = addr[21:2];
    exp_be = we ? ~mask : 4'h0;
    exp_wdata = data;
    ram_re_i = re; ram_we_i = we; ram_mask_i = mask; ram_addr_i = addr; ram_data_i = data;
    #1;
    stalls = 0;
    for (int k = 0; k < 32 && stallreq_o; k++) begin
      stalls++;
      @(posedge clk); #1;
    end
    e_st = 0; e_we = 0; e_oe = 0; e_ce = 0; e_doe = 0;
    if (we && mask != 4'h0) begin
      e_st = 3 + WW; e_we = WW; e_ce = 2 + WW; e_doe = 2 + WW;
      for (int i = 0; i < 4; i++) if (mask[i]) model_mem[w][8*i +: 8] = data[8*i +: 8];
    end else if (we) begin
      e_st = 1;
    end else if (re) begin
      e_st = 1 + RW; e_oe = RW; e_ce = RW;
      last_rd = model_mem[w];
    end
    chk("stall_cycles", 32'(stalls), 32'(e_st));
    chk("ram_data_o", ram_data_o, last_rd);
    ram_re_i = 1'b0; ram_we_i = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_done", {31'h0, stallreq_o}, 32'h0);
    chk("ce_released", {31'h0, sram_ce_n}, 32'h1);
    chk("we_n_low_cycles", 32'(we_low - s_we), 32'(e_we));
    chk("oe_n_low_cycles", 32'(oe_low - s_oe), 32'(e_oe));
    chk("ce_n_low_cycles", 32'(ce_low - s_ce), 32'(e_ce));
    chk("data_oe_cycles", 32'(doe_high - s_doe), 32'(e_doe));
    chk("strobe_overlap", 32'(overlap - s_ov), 32'h0);
    chk("pin_stability", 32'(pin_err - s_pe), 32'h0);
  endtask

  initial begin
    logic [31:0] a, d;
    int op, w;
    ram_addr_i = '0; ram_data_i = '0; ram_re_i = 1'b0; ram_we_i = 1'b0; ram_mask_i = '0;
    exp_addr = '0; exp_be = 4'hF; exp_wdata = '0;
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we_n", {31'h0, sram_we_n}, 32'h1);
    chk("rst_oe_n", {31'h0, sram_oe_n}, 32'h1);
    chk("rst_ce_n", {31'h0, sram_ce_n}, 32'h1);
    chk("rst_be_n", {28'h0, sram_be_n}, 32'hF);
    chk("rst_data_oe", {31'h0, sram_data_oe}, 32'h0);
    chk("rst_addr", 32'(sram_addr_o), 32'h0);
    chk("rst_wdata", sram_data_o, 32'h0);
    chk("rst_rdata", ram_data_o, 32'h0);
    chk("rst_stall", {31'h0, stallreq_o}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed read of word 4 preloaded with DEADBEEF.
    txn(1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
    chk("rd_sram_addr", 32'(sram_addr_o), 32'h4);
    chk("rd_deadbeef", ram_data_o, 32'hDEAD_BEEF);
    // Partial write, then read back the same word in the next IDLE cycle.
    txn(1'b0, 1'b1, 4'b0011, 32'h0000_0008, 32'h1234_5678);
    chk("wr_be_n", {28'h0, sram_be_n}, 32'hC);
    txn(1'b1, 1'b0, 4'h0, 32'h0000_0008, 32'h0);
    chk("b2b_readback", ram_data_o, (init_word(2) & 32'hFFFF_0000) | 32'h0000_5678);
    // Simultaneous re/we: write only, read data untouched.
    txn(1'b1, 1'b1, 4'hF, 32'h0000_0014, 32'hCAFE_F00D);
    chk("rewe_rdata_kept", ram_data_o, (init_word(2) & 32'hFFFF_0000) | 32'h0000_5678);
    // Zero-mask write: single stall cycle, no strobes.
    txn(1'b0, 1'b1, 4'h0, 32'h0000_0018, 32'hFFFF_FFFF);
    txn(1'b1, 1'b0, 4'h0, 32'h0000_0014, 32'h0);
    chk("rewe_written", ram_data_o, 32'hCAFE_F00D);

    // Randomized traffic over words 0..14 with junk in ignored address bits.
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 3));
      w  = int'($urandom_range(0, 14));
      a  = {10'($urandom), 16'h0, 4'(w), 2'($urandom)};
      d  = $urandom;
      case (op)
        0:       txn(1'b1, 1'b0, 4'h0, a, d);
        1:       txn(1'b0, 1'b1, 4'($urandom), a, d);
        2:       txn(1'b1, 1'b1, 4'hF, a, d);
        default: txn(1'b0, 1'b1, 4'h0, a, d);
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    // Reset in the middle of the write pulse.
    exp_addr = 20'hF; exp_be = 4'h0; exp_wdata = 32'h0BAD_F00D;
    ram_we_i = 1'b1; ram_mask_i = 4'hF; ram_addr_i = 32'h0000_003C; ram_data_i = 32'h0BAD_F00D;
    for (int k = 0; k < 16 && sram_we_n; k++) begin
      @(posedge clk); #1;
    end
    chk("pulse_reached", {31'h0, sram_we_n}, 32'h0);
    rst = 1'b1; ram_we_i = 1'b0;
    @(posedge clk); #1;
    chk("abort_we_n", {31'h0, sram_we_n}, 32'h1);
    chk("abort_ce_n", {31'h0, sram_ce_n}, 32'h1);
    chk("abort_data_oe", {31'h0, sram_data_oe}, 32'h0);
    chk("abort_stall", {31'h0, stallreq_o}, 32'h0);
    chk("abort_rdata", ram_data_o, 32'h0);
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    txn(1'b1, 1'b0, 4'h0, 32'h0000_0004, 32'h0);
    chk("post_abort_read", ram_data_o, init_word(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
